sprite_fetcher: RTL and testbench
=================================

SPRITE_FETCHER -- requirements
Module: sprite_fetcher

Interface
REQ-001 Parameter KEY, default 8'h00: colour-key byte value; used only when SPRITE_FETCH_KEY_EN is defined.
REQ-002 Port Clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port Reset, input, 1: synchronous, active-high reset.
REQ-004 Port start, input, 1: request pulse; sampled only while busy=0.
REQ-005 Port base, input, 8: first memory address of the run; captured when start is accepted.
REQ-006 Port len, input, 8: number of bytes in the run (0..255); captured when start is accepted.
REQ-007 Port mem_addr, output, 8: address to the 8-bit-addressed, 1-cycle registered-read memory.
REQ-008 Port mem_data, input, 8: memory read data; valid in the cycle after mem_addr was presented.
REQ-009 Port pix_data, output, 8: streamed byte.
REQ-010 Port pix_valid, output, 1: pix_data is valid.
REQ-011 Port pix_ready, input, 1: consumer accepts; a byte transfers when pix_valid and pix_ready are both 1.
REQ-012 Port busy, output, 1: a run is in progress.
REQ-013 Port done, output, 1: one-cycle pulse at the end of a run.
REQ-014 Port pix_key, output, 1: pix_data equals KEY; present only with SPRITE_FETCH_KEY_EN.

Function
REQ-015 The block SHALL implement states IDLE, FETCH, DRAIN and DONE.
REQ-016 IDLE with start=1 SHALL capture base and len, set busy=1, and go to FETCH (or DONE if len=0).
REQ-017 start while busy=1 SHALL be ignored; base and len SHALL not be re-captured.
REQ-018 FETCH SHALL issue one address per cycle while buffer occupancy + in-flight reads - pops this cycle < 2.
REQ-019 Issued addresses SHALL be base, base+1, ... modulo 256 (255 wraps to 0).
REQ-020 The block SHALL write mem_data into a 2-entry FIFO exactly one cycle after each issue; no byte SHALL be dropped or duplicated.
REQ-021 After len issues, FETCH SHALL move to DRAIN; DRAIN SHALL move to DONE when the FIFO is empty, no read is in flight, and the last byte has transferred.
REQ-022 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-023 The first pix_valid SHALL assert in the 3rd cycle after the start-accepting edge; with pix_ready held at 1, throughput SHALL be 1 byte per cycle.
REQ-024 pix_data and pix_valid SHALL stay stable while pix_valid=1 and pix_ready=0.
REQ-025 A len=0 start SHALL produce no pix_valid, and done SHALL pulse in the cycle after acceptance.
REQ-026 mem_addr SHALL hold its last issued value when no read is being issued.

Reset
REQ-027 Reset=1 SHALL force state IDLE, mem_addr=0, pix_valid=0, pix_data=0, busy=0, done=0 and pix_key=0, clear the FIFO, and discard in-flight reads.
REQ-028 Reset asserted mid-run SHALL abort the run without a done pulse; no stale byte SHALL appear after Reset deasserts.

Configuration
REQ-029 With SPRITE_FETCH_KEY_EN defined, pix_key SHALL be registered alongside its FIFO entry and equal (pix_data == KEY) whenever pix_valid=1.
REQ-030 Without SPRITE_FETCH_KEY_EN, the pix_key port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Preload mem[35..42]={49,49,49,49,52,52,52,49}; start base=35, len=8, pix_ready=1 -> pix_valid first asserts in cycle 3; 8 consecutive bytes in that order; done pulses once.
REQ-032 Same run with pix_ready toggling 1,0,0,1,... -> same 8 bytes, each held stable while stalled; mem_addr never runs more than 2 reads ahead.
REQ-033 base=254, len=4 -> addresses 254,255,0,1 issued; 4 bytes out.
REQ-034 len=0 -> no pix_valid; done in the next cycle; start pulsed again while busy during a len=8 run -> ignored, exactly 8 bytes out.
REQ-035 Reset after the 3rd byte of a len=8 run -> all outputs 0 in the next cycle; no done pulse; a new run then starts cleanly.
REQ-036 With SPRITE_FETCH_KEY_EN and KEY=8'h00, fetch mem[0..3]={00,00,00,49} -> pix_key=1,1,1,0.

Source files
------------

// File: rtl/sprite_fetcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sprite_fetcher: streams a run of bytes from a 1-cycle registered-read     |
// | memory through a 2-entry FIFO to a valid/ready consumer.                  |
// | Optional: SPRITE_FETCH_KEY_EN adds the pix_key colour-key flag output.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module sprite_fetcher #(
  parameter logic [7:0] KEY = 8'h00
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [7:0] base,
  input  logic [7:0] len,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       busy,
  output logic       done
`ifdef SPRITE_FETCH_KEY_EN
  ,
  output logic       pix_key
`endif
);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_FETCH = 2'd1;
  localparam logic [1:0] c_S_DRAIN = 2'd2;
  localparam logic [1:0] c_S_DONE  = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [7:0] r_addr;
  logic [7:0] r_last_addr;
  logic [7:0] r_remain;
  logic       r_inflight;
  logic [7:0] r_fifo [0:1];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_count;
  logic       w_pop;
  logic       w_room;
  logic       w_issue;

  assign pix_valid = (r_count != 2'd0);
  assign w_pop     = pix_valid & pix_ready;
  // Occupancy + in-flight - pops this cycle must stay below the FIFO depth.
  assign w_room    = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  assign mem_addr  = w_issue ? r_addr : r_last_addr;
  assign pix_data  = pix_valid ? r_fifo[r_rd_ptr] : 8'h00;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE:  if (start) w_next_state = (len == 8'd0) ? c_S_DONE : c_S_FETCH;
      c_S_FETCH: if (w_issue && (r_remain == 8'd1)) w_next_state = c_S_DRAIN;
      c_S_DRAIN: if ((r_count == 2'd0) && !r_inflight) w_next_state = c_S_DONE;
      default:   w_next_state = c_S_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    w_issue = 1'b0;
    case (r_state)
      c_S_FETCH: begin
        busy    = 1'b1;
        w_issue = w_room;
      end
      c_S_DRAIN: busy = 1'b1;
      c_S_DONE:  done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_addr      <= 8'h00;
      r_last_addr <= 8'h00;
      r_remain    <= 8'h00;
      r_inflight  <= 1'b0;
      r_fifo[0]   <= 8'h00;
      r_fifo[1]   <= 8'h00;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      if ((r_state == c_S_IDLE) && start) begin
        r_addr   <= base;
        r_remain <= len;
      end
      if (w_issue) begin
        r_addr      <= r_addr + 8'd1;
        r_last_addr <= r_addr;
        r_remain    <= r_remain - 8'd1;
      end
      // Read data returns the cycle after its address is presented.
      r_inflight <= w_issue;
      if (r_inflight) begin
        r_fifo[r_wr_ptr] <= mem_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

`ifdef SPRITE_FETCH_KEY_EN
  logic r_key [0:1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_key[0] <= 1'b0;
      r_key[1] <= 1'b0;
    end else if (r_inflight) begin
      r_key[r_wr_ptr] <= (mem_data == KEY);
    end
  end

  assign pix_key = pix_valid & r_key[r_rd_ptr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetcher.sv
`default_nettype none
// tb_sprite_fetcher: randomized self-checking bench with a byte-stream model.
module tb_sprite_fetcher;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base = 8'h00;
  logic [7:0] len = 8'h00;
  logic [7:0] mem_addr;
  logic [7:0] mem_data = 8'h00;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready = 1'b1;
  logic       busy;
  logic       done;
`ifdef SPRITE_FETCH_KEY_EN
  logic       pix_key;
`endif

  logic [7:0] mem [0:255];
  int total = 0;
  int bad = 0;

  // Observations collected by do_run for the test tasks to judge.
  logic [7:0] q_bytes[$];
  logic [7:0] addr_q[$];
  logic       key_q[$];
  int first_valid, last_xfer, done_cnt, done_cyc, stall_bad, max_ahead, key_bad;
  bit timed_out;

  sprite_fetcher u_dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base(base), .len(len),
    .mem_addr(mem_addr), .mem_data(mem_data), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy), .done(done)
`ifdef SPRITE_FETCH_KEY_EN
    , .pix_key(pix_key)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) mem_data <= mem[mem_addr];

  // Reference: the run is mem[base], mem[base+1], ... (mod 256), len bytes.
  function automatic int seq_errs(input logic [7:0] b, input logic [7:0] l);
    int e = (q_bytes.size() == int'(l)) ? 0 : 1;
    for (int i = 0; i < q_bytes.size() && i < int'(l); i++)
      if (q_bytes[i] !== mem[8'(int'(b) + i)]) e++;
    return e;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  task automatic do_run(input logic [7:0] b, input logic [7:0] l, input int mode, input bit extra);
    int c = 0;
    logic pv = 1'b0, pr = 1'b1;
    logic [7:0] pd = 8'h00;
    int ahead;
    q_bytes.delete(); addr_q.delete(); key_q.delete();
    first_valid = -1; last_xfer = -1; done_cnt = 0; done_cyc = -1;
    stall_bad = 0; max_ahead = 0; key_bad = 0; timed_out = 0;
    @(negedge Clk);
    start = 1'b1; base = b; len = l; pix_ready = 1'b1;
    while (!timed_out) begin
      @(negedge Clk);
      c++;
      start = extra && (c == 4);
      if (start) begin base = b ^ 8'h55; len = 8'd3; end
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ((c - 1) % 3 == 0);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (pix_valid && first_valid < 0) first_valid = c;
      if (pv && !pr && (!pix_valid || pix_data !== pd)) stall_bad++;
      pv = pix_valid; pr = pix_ready; pd = pix_data;
      if (pix_valid && pix_ready) begin
        q_bytes.push_back(pix_data);
        last_xfer = c;
`ifdef SPRITE_FETCH_KEY_EN
        key_q.push_back(pix_key);
`endif
      end
`ifdef SPRITE_FETCH_KEY_EN
      if (pix_valid && (pix_key !== (pix_data == 8'h00))) key_bad++;
`endif
      if (busy) begin
        ahead = int'(8'(mem_addr - b)) + 1 - q_bytes.size();
        if (ahead > max_ahead) max_ahead = ahead;
        if (addr_q.size() == 0 || addr_q[$] !== mem_addr) addr_q.push_back(mem_addr);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      if (c >= 400) timed_out = 1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      start = 1'b1; base = 8'($urandom); len = 8'd5;
    end
    #1;
    total++;
    if ({pix_valid, busy, done} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl: got valid/busy/done=%b want 000", {pix_valid, busy, done});
    end
    total++;
    if ({mem_addr, pix_data} !== 16'h0000) begin
      bad++; $display("FAIL reset_data: got addr=%0d data=%0d want 0 0", mem_addr, pix_data);
    end
    @(negedge Clk);
    start = 1'b0; Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    logic [7:0] pat [0:7] = '{8'd49, 8'd49, 8'd49, 8'd49, 8'd52, 8'd52, 8'd52, 8'd49};
    for (int i = 0; i < 8; i++) mem[35 + i] = pat[i];
    do_run(8'd35, 8'd8, 0, 0);
    total++;
    if (timed_out) begin bad++; $display("FAIL basic_timeout: run did not finish, want done"); end
    total++;
    if (seq_errs(8'd35, 8'd8) != 0) begin
      bad++; $display("FAIL basic_bytes: got %0d bytes with %0d errors want 8 exact", q_bytes.size(), seq_errs(8'd35, 8'd8));
    end
    total++;
    if (first_valid != 3) begin bad++; $display("FAIL basic_latency: got cycle %0d want 3", first_valid); end
    total++;
    if (last_xfer != 10) begin bad++; $display("FAIL basic_throughput: last byte cycle %0d want 10", last_xfer); end
    total++;
    if (done_cnt != 1 || done_cyc <= last_xfer) begin
      bad++; $display("FAIL basic_done: got %0d pulses at %0d want 1 after %0d", done_cnt, done_cyc, last_xfer);
    end
  endtask

  task automatic test_stall();
    do_run(8'd35, 8'd8, 1, 0);
    total++;
    if (seq_errs(8'd35, 8'd8) != 0 || timed_out) begin
      bad++; $display("FAIL stall_bytes: got %0d bytes timeout=%0d want 8 exact", q_bytes.size(), timed_out);
    end
    total++;
    if (stall_bad != 0) begin bad++; $display("FAIL stall_stable: got %0d changes want 0", stall_bad); end
    total++;
    if (max_ahead > 2) begin bad++; $display("FAIL stall_ahead: got %0d reads ahead want <=2", max_ahead); end
  endtask

  task automatic test_wrap();
    fill_mem();
    do_run(8'd254, 8'd4, 2, 0);
    total++;
    if (addr_q.size() != 4 || addr_q[0] !== 8'd254 || addr_q[1] !== 8'd255 ||
        addr_q[2] !== 8'd0 || addr_q[3] !== 8'd1) begin
      bad++; $display("FAIL wrap_addr: got %0d addresses first=%0d want 254,255,0,1", addr_q.size(), addr_q.size() ? addr_q[0] : 0);
    end
    total++;
    if (seq_errs(8'd254, 8'd4) != 0 || timed_out) begin
      bad++; $display("FAIL wrap_bytes: got %0d bytes want 4 exact", q_bytes.size());
    end
  endtask

  task automatic test_len_zero();
    do_run(8'($urandom), 8'd0, 0, 0);
    total++;
    if (first_valid != -1) begin bad++; $display("FAIL len0_valid: pix_valid at cycle %0d want never", first_valid); end
    total++;
    if (done_cyc != 1 || done_cnt != 1) begin
      bad++; $display("FAIL len0_done: got %0d pulses at cycle %0d want 1 at 1", done_cnt, done_cyc);
    end
  endtask

  task automatic test_busy_start();
    fill_mem();
    do_run(8'd100, 8'd8, 0, 1);
    total++;
    if (seq_errs(8'd100, 8'd8) != 0 || timed_out) begin
      bad++; $display("FAIL busy_start_bytes: got %0d bytes want 8 exact", q_bytes.size());
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL busy_start_done: got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_run();
    int xf = 0;
    int cyc = 0;
    int stray = 0;
    fill_mem();
    @(negedge Clk);
    start = 1'b1; base = 8'd60; len = 8'd8; pix_ready = 1'b1;
    while (xf < 3 && cyc < 50) begin
      @(negedge Clk);
      start = 1'b0; cyc++;
      #1;
      if (pix_valid && pix_ready) xf++;
    end
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    total++;
    if ({pix_valid, busy, done, mem_addr, pix_data} !== 19'd0) begin
      bad++; $display("FAIL midreset_outputs: got v=%b b=%b d=%b a=%0d p=%0d want all 0",
                      pix_valid, busy, done, mem_addr, pix_data);
    end
    @(negedge Clk);
    Reset = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      #1;
      if (pix_valid || done || busy) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL midreset_stale: got %0d active cycles want 0", stray); end
    do_run(8'd200, 8'd6, 2, 0);
    total++;
    if (seq_errs(8'd200, 8'd6) != 0 || timed_out || done_cnt != 1) begin
      bad++; $display("FAIL midreset_rerun: got %0d bytes %0d done want 6 exact 1", q_bytes.size(), done_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] b, l;
    for (int r = 0; r < 12; r++) begin
      fill_mem();
      b = 8'($urandom);
      l = 8'($urandom_range(1, 24));
      do_run(b, l, 2, 0);
      total++;
      if (seq_errs(b, l) != 0 || timed_out) begin
        bad++; $display("FAIL rand_bytes[%0d]: got %0d bytes want %0d exact", r, q_bytes.size(), l);
      end
      total++;
      if (stall_bad != 0 || max_ahead > 2 || done_cnt != 1 || done_cyc <= last_xfer) begin
        bad++; $display("FAIL rand_proto[%0d]: stall=%0d ahead=%0d done=%0d want 0 <=2 1", r, stall_bad, max_ahead, done_cnt);
      end
    end
  endtask

`ifdef SPRITE_FETCH_KEY_EN
  task automatic test_key();
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'd49;
    do_run(8'd0, 8'd4, 2, 0);
    total++;
    if (key_q.size() != 4 || key_q[0] !== 1'b1 || key_q[1] !== 1'b1 || key_q[2] !== 1'b1 || key_q[3] !== 1'b0) begin
      bad++; $display("FAIL key_flags: got %0d flags want 1,1,1,0", key_q.size());
    end
    total++;
    if (key_bad != 0) begin bad++; $display("FAIL key_match: got %0d bad cycles want 0", key_bad); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_len_zero();
    test_busy_start();
    test_reset_mid_run();
    test_random();
`ifdef SPRITE_FETCH_KEY_EN
    test_key();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
